// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core's SQI memory interface.
package idli_pkg;

  typedef logic [1:0]  ctr_t;
  typedef logic [15:0] data_t;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StDummy,
    StData,
    StEnd
  } sqi_state_t;

  localparam int unsigned SQI_ADDR_NIBS = 6;
  localparam int unsigned SQI_CMD_NIBS  = 2;

  // Nibble idx (0 = MSB) of the 24b byte address built from a 16b word address.
  function automatic logic [3:0] addr_nib(input logic [15:0] addr, input logic [2:0] idx);
    logic [23:0] byte_addr;
    byte_addr = {7'b0, addr, 1'b0};
    case (idx)
      3'd0:    addr_nib = byte_addr[23:20];
      3'd1:    addr_nib = byte_addr[19:16];
      3'd2:    addr_nib = byte_addr[15:12];
      3'd3:    addr_nib = byte_addr[11:8];
      3'd4:    addr_nib = byte_addr[7:4];
      default: addr_nib = byte_addr[3:0];
    endcase
  endfunction

endpackage

// File: rtl/idli_sqi_shreg_m.sv
// 16b nibble shift register shared by the SQI TX and RX data paths.
module idli_sqi_shreg_m
  import idli_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  data_t      data_i,
  input  logic       shift_i,
  input  logic [3:0] nib_i,
  output data_t      word_o
);

  data_t word_q;

  // Shift right: TX emits word_q[3:0] first, RX fills from the top nibble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q <= '0;
    end else if (load_i) begin
      word_q <= data_i;
    end else if (shift_i) begin
      word_q <= {nib_i, word_q[15:4]};
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/idli_sqi_tx_m.sv
// SQI memory-side master: command/address/data serialiser and read deserialiser.
// Optional: IDLI_SQI_TX_REDIRECT_EN accepts a new request at a DATA word boundary.
module idli_sqi_tx_m
  import idli_pkg::*;
#(
  parameter logic [7:0]  CMD_RD       = 8'h03,
  parameter logic [7:0]  CMD_WR       = 8'h02,
  parameter int unsigned DUMMY_CYCLES = 2
) (
  input  logic        i_sq_gck,
  input  logic        i_sq_rst,
  input  logic        i_sq_req,
  input  logic        i_sq_wr,
  input  logic [15:0] i_sq_addr,
  input  logic        i_sq_stop,
  input  logic [15:0] i_sq_wr_data,
  output logic        o_sq_wr_rdy,
  output logic [15:0] o_sq_rd_data,
  output logic        o_sq_rd_vld,
  output logic [1:0]  o_sq_ctr,
  output logic        o_sq_busy,
  output logic        o_sqi_cs_n,
  output logic [3:0]  o_sqi_sio,
  output logic        o_sqi_oe,
  input  logic [3:0]  i_sqi_sio
);

  localparam logic [2:0] CmdLast   = 3'(SQI_CMD_NIBS - 1);
  localparam logic [2:0] AddrLast  = 3'(SQI_ADDR_NIBS - 1);
  localparam logic [2:0] DummyLast = 3'(DUMMY_CYCLES - 1);

  sqi_state_t  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic        redir_q, redir_d;
  logic        rd_vld_q, rd_vld_d;
  data_t       rd_data_q, rd_data_d;

  logic        sh_load, sh_shift;
  data_t       sh_word;
  logic [7:0]  cmd;

  assign cmd = wr_q ? CMD_WR : CMD_RD;

  idli_sqi_shreg_m u_shreg (
    .clk_i   (i_sq_gck),
    .rst_i   (i_sq_rst),
    .load_i  (sh_load),
    .data_i  (i_sq_wr_data),
    .shift_i (sh_shift),
    .nib_i   (i_sqi_sio),
    .word_o  (sh_word)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 3'd1;
    wr_d        = wr_q;
    addr_d      = addr_q;
    redir_d     = redir_q;
    rd_vld_d    = 1'b0;
    rd_data_d   = rd_data_q;
    sh_load     = 1'b0;
    sh_shift    = 1'b0;
    o_sq_wr_rdy = 1'b0;
    o_sq_ctr    = '0;
    o_sq_busy   = 1'b1;
    o_sqi_cs_n  = 1'b0;
    o_sqi_oe    = 1'b0;
    o_sqi_sio   = '0;

    unique case (state_q)
      StIdle: begin
        o_sqi_cs_n = 1'b1;
        o_sq_busy  = 1'b0;
        cnt_d      = '0;
        if (i_sq_req) begin
          state_d = StCmd;
          wr_d    = i_sq_wr;
          addr_d  = i_sq_addr;
        end
      end
      StCmd: begin
        o_sqi_oe  = 1'b1;
        o_sqi_sio = cnt_q[0] ? cmd[3:0] : cmd[7:4];
        if (cnt_q == CmdLast) begin
          state_d = StAddr;
          cnt_d   = '0;
        end
      end
      StAddr: begin
        o_sqi_oe  = 1'b1;
        o_sqi_sio = addr_nib(addr_q, cnt_q);
        if (cnt_q == AddrLast) begin
          cnt_d = '0;
          if (!wr_q) begin
            state_d = StDummy;
          end else begin
            o_sq_wr_rdy = 1'b1;
            if (i_sq_stop) begin
              state_d = StEnd;
            end else begin
              state_d = StData;
              sh_load = 1'b1;
            end
          end
        end
      end
      StDummy: begin
        if (cnt_q == DummyLast) begin
          state_d = StData;
          cnt_d   = '0;
        end
      end
      StData: begin
        o_sq_ctr = cnt_q[1:0];
        cnt_d    = {1'b0, cnt_q[1:0] + 2'd1};
        sh_shift = 1'b1;
        if (wr_q) begin
          o_sqi_oe  = 1'b1;
          o_sqi_sio = sh_word[3:0];
        end
        if (cnt_q[1:0] == 2'd3) begin
          if (wr_q) begin
            o_sq_wr_rdy = 1'b1;
            if (i_sq_stop) begin
              state_d = StEnd;
            end else begin
              sh_load = 1'b1;
            end
          end else begin
            // The nibble on the bus now completes the word.
            rd_vld_d  = 1'b1;
            rd_data_d = {i_sqi_sio, sh_word[15:4]};
            if (i_sq_stop) begin
              state_d = StEnd;
            end
          end
`ifdef IDLI_SQI_TX_REDIRECT_EN
          if (i_sq_req) begin
            state_d = StEnd;
            sh_load = 1'b0;
            redir_d = 1'b1;
            addr_d  = i_sq_addr;
            wr_d    = i_sq_wr;
          end
`else
          redir_d = 1'b0;
`endif
        end
      end
      StEnd: begin
        o_sqi_cs_n = 1'b1;
        cnt_d      = '0;
        redir_d    = 1'b0;
        state_d    = redir_q ? StCmd : StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_sq_gck) begin
    if (i_sq_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      redir_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      redir_q   <= redir_d;
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign o_sq_rd_vld  = rd_vld_q;
  assign o_sq_rd_data = rd_data_q;

endmodule

// File: tb/tb_idli_sqi_tx_m.sv
// Scoreboard bench for idli_sqi_tx_m: bus nibbles and read words checked by a monitor.
module tb_idli_sqi_tx_m;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = '0;
  logic        stop = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_rdy;
  logic [15:0] rd_data;
  logic        rd_vld;
  logic [1:0]  ctr;
  logic        busy;
  logic        cs_n;
  logic [3:0]  sio_o;
  logic        oe;
  logic [3:0]  sio_i = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [15:0] d;
    int          c;
  } exp_rd_t;

  logic [3:0]  exp_nib[$];
  exp_rd_t     exp_rd[$];
  logic [15:0] rd_words[3];

  idli_sqi_tx_m dut (
    .i_sq_gck     (clk),
    .i_sq_rst     (rst),
    .i_sq_req     (req),
    .i_sq_wr      (wr),
    .i_sq_addr    (addr),
    .i_sq_stop    (stop),
    .i_sq_wr_data (wr_data),
    .o_sq_wr_rdy  (wr_rdy),
    .o_sq_rd_data (rd_data),
    .o_sq_rd_vld  (rd_vld),
    .o_sq_ctr     (ctr),
    .o_sq_busy    (busy),
    .o_sqi_cs_n   (cs_n),
    .o_sqi_sio    (sio_o),
    .o_sqi_oe     (oe),
    .i_sqi_sio    (sio_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Nibbles listed MSB-first in seq are the expected bus order.
  task automatic push_seq(input logic [63:0] seq, input int n);
    for (int k = 0; k < n; k++) exp_nib.push_back(seq[4*(n-1-k) +: 4]);
  endtask

  // Monitor: every driven bus nibble and every read word is matched against the queues.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!cs_n && oe) begin
        if (exp_nib.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sio_extra: got %0h expected no driven nibble (cycle %0d)", sio_o, cyc);
        end else begin
          chk("sio", {28'd0, sio_o}, {28'd0, exp_nib.pop_front()});
        end
      end
      if (rd_vld) begin
        if (exp_rd.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_extra: got %0h expected no rd_vld (cycle %0d)", rd_data, cyc);
        end else begin
          exp_rd_t e;
          e = exp_rd.pop_front();
          chk("rd_data", {16'd0, rd_data}, {16'd0, e.d});
          chk("rd_cycle", cyc, e.c);
        end
      end
    end
  end

  // Called in cycle n0+1 of a read whose req was in cycle n0; returns at its end.
  task automatic read_data(input int n0, input int n, input bit redir,
                           input logic [63:0] rhdr, input logic [15:0] raddr);
    for (int w = 0; w < n; w++) exp_rd.push_back('{d: rd_words[w], c: n0 + 15 + 4*w});
    repeat (8) tick();
    chk("dummy_oe", {31'd0, oe}, 32'd0);
    chk("dummy_cs_n", {31'd0, cs_n}, 32'd0);
    tick();
    for (int w = 0; w < n; w++) begin
      for (int i = 0; i < 4; i++) begin
        tick();
        sio_i = rd_words[w][4*i +: 4];
        chk("rd_ctr", {30'd0, ctr}, i);
        if (w == n - 1 && i == 3) begin
          if (redir) begin
            req  = 1'b1;
            wr   = 1'b0;
            addr = raddr;
            push_seq(rhdr, 8);
          end else begin
            stop = 1'b1;
          end
        end
      end
    end
    tick();
    stop  = 1'b0;
    req   = 1'b0;
    sio_i = '0;
    chk("end_cs_n", {31'd0, cs_n}, 32'd1);
    chk("end_busy", {31'd0, busy}, 32'd1);
    chk("end_oe", {31'd0, oe}, 32'd0);
    tick();
    if (redir) begin
      chk("redir_cs_n", {31'd0, cs_n}, 32'd0);
      chk("redir_busy", {31'd0, busy}, 32'd1);
    end else begin
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_cs_n", {31'd0, cs_n}, 32'd1);
    end
  endtask

  initial begin
    int n0;
    repeat (2) tick();
    chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("rst_oe", {31'd0, oe}, 32'd0);
    chk("rst_sio", {28'd0, sio_o}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ctr", {30'd0, ctr}, 32'd0);
    chk("rst_rd_vld", {31'd0, rd_vld}, 32'd0);
    chk("rst_wr_rdy", {31'd0, wr_rdy}, 32'd0);
    chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Single read of 0x1234; memory returns nibbles 4,3,2,1.
    n0 = cyc;
    req = 1'b1; wr = 1'b0; addr = 16'h1234;
    push_seq(64'h03002468, 8);
    tick();
    req = 1'b0;
    chk("cmd_cs_n", {31'd0, cs_n}, 32'd0);
    chk("cmd_busy", {31'd0, busy}, 32'd1);
    chk("cmd_oe", {31'd0, oe}, 32'd1);
    rd_words[0] = 16'h1234;
    read_data(n0, 1, 1'b0, 64'd0, 16'd0);
    chk("rd_data_hold", {16'd0, rd_data}, 32'h1234);

    // Write 0xBEEF at 0x0010, stop at the following wr_rdy.
    n0 = cyc;
    req = 1'b1; wr = 1'b1; addr = 16'h0010; wr_data = 16'hBEEF;
    push_seq(64'h02000020FEEB, 12);
    tick();
    req = 1'b0;
    repeat (7) tick();
    chk("wr_rdy_addr", {31'd0, wr_rdy}, 32'd1);
    tick();
    wr_data = 16'h1111;
    chk("wr_rdy_d0", {31'd0, wr_rdy}, 32'd0);
    chk("wr_ctr0", {30'd0, ctr}, 32'd0);
    chk("wr_oe", {31'd0, oe}, 32'd1);
    repeat (3) tick();
    chk("wr_ctr3", {30'd0, ctr}, 32'd3);
    chk("wr_rdy_d3", {31'd0, wr_rdy}, 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("wr_end_cs_n", {31'd0, cs_n}, 32'd1);
    chk("wr_end_busy", {31'd0, busy}, 32'd1);
    chk("wr_end_oe", {31'd0, oe}, 32'd0);
    tick();
    chk("wr_idle_busy", {31'd0, busy}, 32'd0);

    // Burst read of three words from 0x0000, stop on the third.
    rd_words[0] = 16'hA5C3;
    rd_words[1] = 16'h0F1E;
    rd_words[2] = 16'h7788;
    n0 = cyc;
    req = 1'b1; wr = 1'b0; addr = 16'h0000;
    push_seq(64'h03000000, 8);
    tick();
    req = 1'b0;
    read_data(n0, 3, 1'b0, 64'd0, 16'd0);

    // Write stopped on the first wr_rdy: no data phase at all.
    n0 = cyc;
    req = 1'b1; wr = 1'b1; addr = 16'hABCD; wr_data = 16'h5555;
    push_seq(64'h0201579A, 8);
    tick();
    req = 1'b0;
    repeat (7) tick();
    chk("wr0_rdy", {31'd0, wr_rdy}, 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("wr0_end_cs_n", {31'd0, cs_n}, 32'd1);
    chk("wr0_end_busy", {31'd0, busy}, 32'd1);
    chk("wr0_end_oe", {31'd0, oe}, 32'd0);
    tick();
    chk("wr0_idle_busy", {31'd0, busy}, 32'd0);

    // Reset during ADDR, then a clean read restart.
    n0 = cyc;
    req = 1'b1; wr = 1'b0; addr = 16'h1234;
    push_seq(64'h0300, 4);
    tick();
    req = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_cs_n", {31'd0, cs_n}, 32'd1);
    chk("rst_mid_oe", {31'd0, oe}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    rd_words[0] = 16'h9D6B;
    n0 = cyc;
    req = 1'b1; addr = 16'h0001;
    push_seq(64'h03000002, 8);
    tick();
    req = 1'b0;
    read_data(n0, 1, 1'b0, 64'd0, 16'd0);

`ifdef IDLI_SQI_TX_REDIRECT_EN
    // Redirect at the word boundary of a read to 0x0100.
    rd_words[0] = 16'h4C2E;
    n0 = cyc;
    req = 1'b1; wr = 1'b0; addr = 16'h0000;
    push_seq(64'h03000000, 8);
    tick();
    req = 1'b0;
    read_data(n0, 1, 1'b1, 64'h03000200, 16'h0100);
    rd_words[0] = 16'h3B71;
    read_data(n0 + 15, 1, 1'b0, 64'd0, 16'd0);
`endif

    repeat (3) tick();
    chk("nib_queue_empty", exp_nib.size(), 32'd0);
    chk("rd_queue_empty", exp_rd.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/idli_sqi_tx_m.md
Name: idli_sqi_tx_m

Overview:
SQI memory-side master. It serialises command, address and write data onto the 4-bit SQI bus, and deserialises read data into 16b words. It produces the fetch and load stream that the instruction decode and execute stages consume, with each word synchronised to the 2-bit nibble counter. Sits between the core's memory request logic and the external SQI SRAM pins.

Parameters:
CMD_RD, 8'h03, SQI read command byte.
CMD_WR, 8'h02, SQI write command byte.
DUMMY_CYCLES, 2, bus-turnaround cycles between address and read data (range 1-4).

Ports:
i_sq_gck  in  1  clock; single domain.
i_sq_rst  in  1  reset; synchronous, active-high.
i_sq_req  in  1  start transaction; sampled only in IDLE.
i_sq_wr  in  1  1=write, 0=read; latched with i_sq_req.
i_sq_addr  in  16  word address; latched with i_sq_req.
i_sq_stop  in  1  end burst at the next word boundary.
i_sq_wr_data  in  16  write word; sampled on the edge where o_sq_wr_rdy=1.
o_sq_wr_rdy  out  1  write word will be taken at this edge.
o_sq_rd_data  out  16  assembled read word.
o_sq_rd_vld  out  1  one-cycle pulse; o_sq_rd_data valid.
o_sq_ctr  out  2  nibble index within the current data word.
o_sq_busy  out  1  transaction in progress.
o_sqi_cs_n  out  1  SQI chip select, active low.
o_sqi_sio  out  4  SQI data out.
o_sqi_oe  out  1  SQI output enable for o_sqi_sio.
i_sqi_sio  in  4  SQI data in.

Behaviour:
- Reset values: cs_n=1; oe=0; sio=0; busy=0; ctr=0; rd_vld=0; wr_rdy=0; rd_data=0; state=IDLE.
- Reset mid-transaction: state returns to IDLE and cs_n=1 on the next cycle. The memory discards the partial access.
- States: IDLE, CMD (2 cycles), ADDR (6), DUMMY (DUMMY_CYCLES; reads only), DATA (unbounded), END (1).
- IDLE: i_sq_req=1 in cycle N latches addr and wr.
  - Cycle N+1 onward: state=CMD, cs_n=0, oe=1, busy=1.
  - i_sq_req is ignored while busy.
- CMD: drives command byte MSB nibble first.
- ADDR: drives 24b byte address {7'b0, addr, 1'b0}, MSB nibble first.
- Write path:
  - ADDR goes directly to DATA.
  - o_sq_wr_rdy=1 in the last ADDR cycle and whenever ctr==3 in DATA.
  - On that edge: if i_sq_stop=1, no word is taken and next state=END. Otherwise i_sq_wr_data is captured.
  - DATA drives nibbles [3:0],[7:4],[11:8],[15:12] in order. ctr counts 0..3 and wraps.
- Read path:
  - ADDR goes to DUMMY with oe=0, then DATA with oe=0.
  - i_sqi_sio is sampled every DATA cycle into nibble ctr, low nibble first.
  - After nibble 3 is sampled, o_sq_rd_vld pulses for 1 cycle with the full word.
  - Read latency: req in cycle N gives first rd_vld in N+15 when DUMMY_CYCLES=2; subsequent words follow every 4 cycles.
  - i_sq_stop is sampled at ctr==3. If set, the current word is the last and next state=END. The final rd_vld still fires.
- END: cs_n=1, oe=0, busy=1, then IDLE with busy=0.
- Address wrap (0xFFFF to 0x0000 in a burst) is the memory's sequential mode; the block is unaware of it.
- o_sq_ctr=0 outside DATA.

Optional Feature:
IDLI_SQI_TX_REDIRECT_EN:
- Defined: i_sq_req is also accepted in DATA at the ctr==3 boundary, with stop implied. New addr and wr are latched, and the block goes END -> CMD directly. busy stays 1, saving the IDLE cycle; used for aux SQI redirects.
- Undefined: i_sq_req is ignored while busy.

Decomposition:
- idli_pkg adds:
  - sqi_state_t enum (IDLE, CMD, ADDR, DUMMY, DATA, END).
  - SQI_ADDR_NIBS=6 and SQI_CMD_NIBS=2.
  - Reuses ctr_t and data_t.
- Sub-module idli_sqi_shreg_m: 16b nibble shift register, parallel load, nibble out/in. Used once for TX and RX, since they are never concurrent.
- The state counter stays in the top module.

Test Plan:
- Read 0x1234: expect sio 0,3 | 0,0,2,4,6,8, then 2 cycles with oe=0. Memory returns 4,3,2,1 -> rd_data=0x1234, rd_vld in N+15.
- Write 0xBEEF @0x0010: expect sio 0,2 | 0,0,0,0,2,0 | F,E,E,B with oe=1 throughout. Then stop at next wr_rdy -> END, cs_n=1 for 1 cycle.
- Burst read 3 words, stop at 3rd ctr==3: expect 3 rd_vld pulses 4 cycles apart, cs_n high 1 cycle after last nibble, busy=0 next.
- Write with stop on first wr_rdy: no data nibbles; END immediately after ADDR; i_sq_wr_data ignored.
- i_sq_rst pulse during ADDR: next cycle cs_n=1, oe=0, busy=0. A new req then restarts cleanly at CMD.
- With REDIRECT_EN, req to 0x0100 at ctr==3 of a read: END 1 cycle, busy stays 1, then CMD/ADDR 0,0,0,2,0,0.
